// File: rtl/block_data_memory_if.sv
// Request/response bundle between a cache controller (master) and the block
// data memory (slave).
interface block_data_memory_if;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    logic        protocol_error;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait, protocol_error
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait, protocol_error
    );
endinterface

// File: rtl/block_data_memory.sv
// 64 x 32 block memory with a fixed multi-cycle access: IDLE -> BUSY (LATENCY
// cycles) -> DONE (one cycle, requests ignored) -> IDLE.
//
// Handshake: a request is one of read/write high in IDLE; busywait rises
// combinationally in that same cycle and stays high through BUSY; busywait low
// while the FSM is in DONE marks completion, and readdata is valid from then on.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    block_data_memory_if.slave    bus,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        op_wr_q, op_wr_d;
    logic [31:0] readdata_q;
    logic        err_q;
    logic        err_set;
    logic        complete;
    logic        busy_comb;
    logic [31:0] mem [64];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        err_set   = 1'b0;
        complete  = 1'b0;
        busy_comb = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read ^ bus.write) begin
                    busy_comb = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_LOAD;
                    addr_d    = bus.address;
                    wdata_d   = bus.writedata;
                    op_wr_d   = bus.write;
                end else if (bus.read && bus.write) begin
                    err_set = 1'b1;
                end
            end
            BUSY: begin
                busy_comb = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 6'd0;
            wdata_q    <= 32'd0;
            op_wr_q    <= 1'b0;
            readdata_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            if (complete && !op_wr_q) begin
                readdata_q <= mem[addr_q];
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Reset clears every word, so a write aborted mid-BUSY leaves nothing behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (complete && op_wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.busywait       = busy_comb && !reset;
    assign bus.readdata       = readdata_q;
    assign bus.protocol_error = err_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: driver issues accesses and queues the
// expected readdata; a monitor checks it whenever the DUT reaches DONE.
module tb_block_data_memory;

    localparam int         LAT    = 5;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clock;
    logic       reset;
    logic [1:0] state;
    logic [1:0] state1;

    block_data_memory_if bus ();
    block_data_memory_if bus1 ();

    block_data_memory #(.LATENCY(LAT)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .state_o (state)
    );

    block_data_memory #(.LATENCY(1)) dut1 (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus1),
        .state_o (state1)
    );

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed access must match the next queued readdata.
    always @(negedge clock) begin
        if (!reset && state == S_DONE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("readdata", bus.readdata, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge while IDLE or DONE; sets up a request and queues its result.
    task automatic issue(input logic is_wr, input logic [5:0] addr,
                         input logic [31:0] data, input logic [31:0] exp, input bit push);
        bus.read      = !is_wr;
        bus.write     = is_wr;
        bus.address   = addr;
        bus.writedata = data;
        if (push) exp_q.push_back(exp);
    endtask

    // Called at the negedge where the request was raised in IDLE; returns at the DONE negedge.
    task automatic wait_done(input logic [5:0] busy_addr);
        int n;
        n = 0;
        @(negedge clock);
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = busy_addr;
        bus.writedata = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busywait) break;
            n++;
            @(negedge clock);
            #1;
        end
        check("busy_cycles", n, LAT);
        check("state_done", state, S_DONE);
    endtask

    task automatic plain_access(input logic is_wr, input logic [5:0] addr,
                                input logic [31:0] data, input logic [31:0] exp);
        @(negedge clock);
        issue(is_wr, addr, data, exp, 1'b1);
        #1;
        check("bw_request", bus.busywait, 1'b1);
        wait_done(addr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = 6'd0; bus.writedata = 32'd0;
        bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = 6'd0; bus1.writedata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_busywait", bus.busywait, 1'b0);
        check("rst_error", bus.protocol_error, 1'b0);
        check("rst_state", state, S_IDLE);

        // Read of a cleared word.
        plain_access(1'b0, 6'h05, 32'h0, 32'h0);

        // Write then back-to-back read with read raised during DONE.
        plain_access(1'b1, 6'h2A, 32'hDEADBEEF, 32'h0);
        issue(1'b0, 6'h2A, 32'h0, 32'hDEADBEEF, 1'b1);
        #1;
        check("bw_done_low", bus.busywait, 1'b0);
        @(negedge clock);
        #1;
        check("b2b_idle", state, S_IDLE);
        check("bw_b2b", bus.busywait, 1'b1);
        wait_done(6'h2A);

        // Address switched during BUSY must not matter.
        @(negedge clock);
        issue(1'b0, 6'h2A, 32'h0, 32'hDEADBEEF, 1'b1);
        #1;
        check("bw_request", bus.busywait, 1'b1);
        wait_done(6'h01);

        // Both read and write: rejected, sticky error, memory intact.
        @(negedge clock);
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 6'h2A; bus.writedata = 32'h0BAD_0BAD;
        #1;
        check("bw_both", bus.busywait, 1'b0);
        @(negedge clock);
        check("err_set", bus.protocol_error, 1'b1);
        check("both_idle", state, S_IDLE);
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clock);
        check("err_sticky", bus.protocol_error, 1'b1);
        plain_access(1'b0, 6'h2A, 32'h0, 32'hDEADBEEF);
        check("err_still", bus.protocol_error, 1'b1);

        // Reset in the 3rd BUSY cycle of a write.
        @(negedge clock);
        @(negedge clock);
        issue(1'b1, 6'h10, 32'h12345678, 32'h0, 1'b0);
        @(negedge clock);
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_mid_busy", state, S_BUSY);
        reset = 1'b1;
        #1;
        check("bw_in_reset", bus.busywait, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_idle", state, S_IDLE);
        check("abort_bw", bus.busywait, 1'b0);
        check("abort_err", bus.protocol_error, 1'b0);
        check("abort_rd", bus.readdata, 32'h0);
        plain_access(1'b0, 6'h10, 32'h0, 32'h0);
        plain_access(1'b0, 6'h2A, 32'h0, 32'h0);

        // LATENCY = 1 instance: one BUSY cycle then DONE.
        @(negedge clock);
        bus1.read = 1'b1; bus1.address = 6'h03;
        #1;
        check("l1_bw_req", bus1.busywait, 1'b1);
        @(negedge clock);
        bus1.read = 1'b0;
        #1;
        check("l1_busy", state1, S_BUSY);
        check("l1_bw_busy", bus1.busywait, 1'b1);
        @(negedge clock);
        #1;
        check("l1_done", state1, S_DONE);
        check("l1_bw_done", bus1.busywait, 1'b0);
        check("l1_rd", bus1.readdata, 32'h0);
        @(negedge clock);
        #1;
        check("l1_idle", state1, S_IDLE);

        repeat (3) @(negedge clock);
        check("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
